// File: rtl/pll_pkg.sv
// Shared definitions for the PLL lock detector.
//   Holds the lock_state encodings, the default tolerance and count constants,
//   and a small absolute-difference helper for tuning-word comparison.
package pll_pkg;

   // lock_state encodings; bit 1 doubles as the "locked" indication
   localparam logic [1:0] ST_UNLOCKED = 2'd0;
   localparam logic [1:0] ST_ACQUIRE  = 2'd1;
   localparam logic [1:0] ST_LOCKED   = 2'd2;
   localparam logic [1:0] ST_HOLD     = 2'd3;

   localparam int unsigned PHASE_TOL_DEF    = 4;
   localparam logic [31:0] TW_TOL_DEF       = 32'd1024;
   localparam int unsigned LOCK_COUNT_DEF   = 16;
   localparam int unsigned UNLOCK_COUNT_DEF = 4;
   localparam int unsigned REF_TIMEOUT_DEF  = 1024;

   localparam int unsigned ERR_W = 8;
   localparam int unsigned TW_W  = 32;

   // Unsigned |a - b| without wrap
   function automatic logic [TW_W-1:0] abs_diff(input logic [TW_W-1:0] a,
                                                 input logic [TW_W-1:0] b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer with optional rising-edge detect.
//   clk  : destination clock
//   rst  : synchronous active-high reset, clears all flops
//   d    : asynchronous input
//   q    : synchronized level
//   rise : one-cycle pulse when q goes 0->1 (tied low when EDGE_EN=0)
module bit_sync #(
   parameter bit EDGE_EN = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

   generate
      if (EDGE_EN) begin : g_edge
         logic prev_q, prev_d;

         always_comb prev_d = sync_q;

         always_ff @(posedge clk) begin
            if (rst) prev_q <= 1'b0;
            else     prev_q <= prev_d;
         end

         assign rise = sync_q & ~prev_q;
      end else begin : g_no_edge
         assign rise = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/lock_detector.sv
// PLL lock detector.
//   Judges each reference window (ref edge to ref edge) on phase-error cycles
//   and tuning-word movement, and walks UNLOCKED/ACQUIRE/LOCKED/HOLD.
//   sys_clk     : sole clock
//   rst         : synchronous active-high reset
//   ref_clk     : asynchronous reference, sampled as data
//   up, down    : asynchronous PFD pulses
//   tuning_word : loop-filter output, stable around ref_clk rise
//   locked      : high in LOCKED or HOLD
//   lock_state  : current state encoding
//   lost_lock   : one-cycle pulse when dropping from LOCKED/HOLD to UNLOCKED
//   ref_lost    : high while the reference is timed out
//   err_last    : saturated error count of the last closed window
module lock_detector
   import pll_pkg::*;
#(
   parameter int unsigned PHASE_TOL    = PHASE_TOL_DEF,
   parameter logic [31:0] TW_TOL       = TW_TOL_DEF,
   parameter int unsigned LOCK_COUNT   = LOCK_COUNT_DEF,
   parameter int unsigned UNLOCK_COUNT = UNLOCK_COUNT_DEF,
   parameter int unsigned REF_TIMEOUT  = REF_TIMEOUT_DEF
) (
   input  logic        sys_clk,
   input  logic        rst,
   input  logic        ref_clk,
   input  logic        up,
   input  logic        down,
   input  logic [31:0] tuning_word,
   output logic        locked,
   output logic [1:0]  lock_state,
   output logic        lost_lock,
   output logic        ref_lost,
   output logic [7:0]  err_last
);

   localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
   localparam int unsigned BAD_W  = $clog2(UNLOCK_COUNT + 1);
   localparam int unsigned TO_W   = $clog2(REF_TIMEOUT + 1);

   localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_COUNT);
   localparam logic [BAD_W-1:0]  BAD_MAX  = BAD_W'(UNLOCK_COUNT);
   localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(REF_TIMEOUT);
   localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(REF_TIMEOUT - 1);
   localparam logic [ERR_W-1:0]  ERR_MAX  = '1;

   // Input synchronizers
   logic ref_edge, up_s, down_s;
   logic ref_sync_unused, up_rise_unused, down_rise_unused;

   bit_sync #(.EDGE_EN(1'b1)) u_sync_ref (
      .clk(sys_clk), .rst(rst), .d(ref_clk), .q(ref_sync_unused), .rise(ref_edge)
   );
   bit_sync #(.EDGE_EN(1'b0)) u_sync_up (
      .clk(sys_clk), .rst(rst), .d(up), .q(up_s), .rise(up_rise_unused)
   );
   bit_sync #(.EDGE_EN(1'b0)) u_sync_down (
      .clk(sys_clk), .rst(rst), .d(down), .q(down_s), .rise(down_rise_unused)
   );

   logic [1:0]        state_q,    state_d;
   logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
   logic [BAD_W-1:0]  bad_cnt_q,  bad_cnt_d;
   logic [TO_W-1:0]   to_cnt_q,   to_cnt_d;
   logic [ERR_W-1:0]  err_cnt_q,  err_cnt_d;
   logic [ERR_W-1:0]  err_last_q, err_last_d;
   logic [TW_W-1:0]   tw_prev_q,  tw_prev_d;
   logic              tw_valid_q, tw_valid_d;
   logic              lost_lock_q, lost_lock_d;
   logic              ref_lost_q, ref_lost_d;

   logic              act;
   logic [TW_W-1:0]   delta;
   logic              good_win;
   logic              timeout;
   logic [GOOD_W-1:0] good_inc;
   logic [BAD_W-1:0]  bad_inc;

   // Window judgement, counters and state machine
   always_comb begin
      state_d     = state_q;
      good_cnt_d  = good_cnt_q;
      bad_cnt_d   = bad_cnt_q;
      err_last_d  = err_last_q;
      tw_prev_d   = tw_prev_q;
      tw_valid_d  = tw_valid_q;
      ref_lost_d  = ref_lost_q;
      lost_lock_d = 1'b0;

      act      = up_s | down_s;
      delta    = abs_diff(tuning_word, tw_prev_q);
      good_win = (32'(err_cnt_q) <= 32'(PHASE_TOL)) && (delta <= TW_TOL) && tw_valid_q;
      good_inc = (good_cnt_q == GOOD_MAX) ? good_cnt_q : good_cnt_q + GOOD_W'(1);
      bad_inc  = (bad_cnt_q == BAD_MAX) ? bad_cnt_q : bad_cnt_q + BAD_W'(1);
      // Level-sensitive once saturated; ref_edge always wins
      timeout  = !ref_edge && (to_cnt_q >= TO_LAST);

      if (ref_edge) begin
         to_cnt_d = '0;
      end else if (to_cnt_q == TO_MAX) begin
         to_cnt_d = to_cnt_q;
      end else begin
         to_cnt_d = to_cnt_q + TO_W'(1);
      end

      // The edge cycle itself opens the new window
      if (ref_edge) begin
         err_cnt_d = ERR_W'(act);
      end else if (act && (err_cnt_q != ERR_MAX)) begin
         err_cnt_d = err_cnt_q + ERR_W'(1);
      end else begin
         err_cnt_d = err_cnt_q;
      end

      if (ref_edge) begin
         err_last_d = err_cnt_q;
         tw_prev_d  = tuning_word;
         tw_valid_d = 1'b1;
         ref_lost_d = 1'b0;
         case (state_q)
            ST_UNLOCKED: begin
               if (good_win) begin
                  state_d    = ST_ACQUIRE;
                  good_cnt_d = GOOD_W'(1);
               end
            end
            ST_ACQUIRE: begin
               if (good_win) begin
                  good_cnt_d = good_inc;
                  if (good_inc >= GOOD_MAX) state_d = ST_LOCKED;
               end else begin
                  state_d    = ST_UNLOCKED;
                  good_cnt_d = '0;
               end
            end
            ST_LOCKED: begin
               if (!good_win) begin
                  state_d   = ST_HOLD;
                  bad_cnt_d = BAD_W'(1);
               end
            end
            ST_HOLD: begin
               if (good_win) begin
                  state_d   = ST_LOCKED;
                  bad_cnt_d = '0;
               end else if (bad_inc >= BAD_MAX) begin
                  state_d     = ST_UNLOCKED;
                  good_cnt_d  = '0;
                  bad_cnt_d   = '0;
                  lost_lock_d = 1'b1;
               end else begin
                  bad_cnt_d = bad_inc;
               end
            end
            default: state_d = ST_UNLOCKED;
         endcase
      end else if (timeout) begin
         state_d     = ST_UNLOCKED;
         good_cnt_d  = '0;
         bad_cnt_d   = '0;
         ref_lost_d  = 1'b1;
         tw_valid_d  = 1'b0;
         lost_lock_d = state_q[1];
      end
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q     <= ST_UNLOCKED;
         good_cnt_q  <= '0;
         bad_cnt_q   <= '0;
         to_cnt_q    <= '0;
         err_cnt_q   <= '0;
         err_last_q  <= '0;
         tw_prev_q   <= '0;
         tw_valid_q  <= 1'b0;
         lost_lock_q <= 1'b0;
         ref_lost_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         good_cnt_q  <= good_cnt_d;
         bad_cnt_q   <= bad_cnt_d;
         to_cnt_q    <= to_cnt_d;
         err_cnt_q   <= err_cnt_d;
         err_last_q  <= err_last_d;
         tw_prev_q   <= tw_prev_d;
         tw_valid_q  <= tw_valid_d;
         lost_lock_q <= lost_lock_d;
         ref_lost_q  <= ref_lost_d;
      end
   end

   assign lock_state = state_q;
   assign locked     = state_q[1];
   assign lost_lock  = lost_lock_q;
   assign ref_lost   = ref_lost_q;
   assign err_last   = err_last_q;

endmodule

// File: tb/tb_lock_detector.sv
// Directed bench for lock_detector: acquisition, hold/unlock, tuning-word
// step, reference timeout, error saturation and mid-window reset.
module tb_lock_detector;

   logic        sys_clk = 1'b0;
   logic        rst;
   logic        ref_clk;
   logic        up;
   logic        down;
   logic [31:0] tuning_word;
   logic        locked;
   logic [1:0]  lock_state;
   logic        lost_lock;
   logic        ref_lost;
   logic [7:0]  err_last;

   int n_checks = 0;
   int n_fail   = 0;
   int ll_cnt   = 0;

   localparam logic [31:0] S_UNL = 32'd0;
   localparam logic [31:0] S_ACQ = 32'd1;
   localparam logic [31:0] S_LCK = 32'd2;
   localparam logic [31:0] S_HLD = 32'd3;

   lock_detector dut (
      .sys_clk(sys_clk), .rst(rst), .ref_clk(ref_clk), .up(up), .down(down),
      .tuning_word(tuning_word), .locked(locked), .lock_state(lock_state),
      .lost_lock(lost_lock), .ref_lost(ref_lost), .err_last(err_last)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   // One ref period: ref high for the first half, up/down high for the first
   // up_cyc/dn_cyc cycles; counts lost_lock pulses seen during the window.
   task automatic run_window(input int period, input int up_cyc, input int dn_cyc,
                             input logic [31:0] tw);
      tuning_word = tw;
      ll_cnt = 0;
      for (int i = 0; i < period; i++) begin
         ref_clk = (i < period / 2);
         up      = (i < up_cyc);
         down    = (i < dn_cyc);
         tick();
         if (lost_lock) ll_cnt++;
      end
   endtask

   task automatic check_reset_outputs(input string pfx);
      check_eq({pfx, "_state"},    32'(lock_state), S_UNL);
      check_eq({pfx, "_locked"},   32'(locked),     32'd0);
      check_eq({pfx, "_lostlock"}, 32'(lost_lock),  32'd0);
      check_eq({pfx, "_reflost"},  32'(ref_lost),   32'd0);
      check_eq({pfx, "_errlast"},  32'(err_last),   32'd0);
   endtask

   initial begin
      rst = 1'b1; ref_clk = 1'b0; up = 1'b0; down = 1'b0; tuning_word = 32'd1000;
      repeat (3) tick();
      check_reset_outputs("rst");
      rst = 1'b0;

      // Clean acquisition: edge 1 primes, edge 2 enters ACQUIRE, edge 17 locks
      for (int w = 1; w <= 17; w++) begin
         run_window(50, 0, 0, 32'd1000);
         if (w == 1)  check_eq("acq_w1_state", 32'(lock_state), S_UNL);
         if (w == 2)  check_eq("acq_w2_state", 32'(lock_state), S_ACQ);
         if (w == 16) check_eq("acq_w16_state", 32'(lock_state), S_ACQ);
      end
      check_eq("acq_w17_state", 32'(lock_state), S_LCK);
      check_eq("acq_locked", 32'(locked), 32'd1);
      check_eq("acq_errlast", 32'(err_last), 32'd0);
      check_eq("acq_reflost", 32'(ref_lost), 32'd0);

      // Two bad windows, then a clean one recovers from HOLD
      run_window(50, 10, 0, 32'd1000);
      check_eq("b1_state", 32'(lock_state), S_LCK);
      run_window(50, 0, 10, 32'd1000);
      check_eq("b2_state", 32'(lock_state), S_HLD);
      check_eq("b2_errlast", 32'(err_last), 32'd10);
      check_eq("b2_locked", 32'(locked), 32'd1);
      run_window(50, 0, 0, 32'd1000);
      check_eq("c_state", 32'(lock_state), S_HLD);
      run_window(50, 0, 10, 32'd1000);
      check_eq("recover_state", 32'(lock_state), S_LCK);
      check_eq("recover_lostlock", 32'(ll_cnt), 32'd0);

      // Four bad windows drop lock; HOLD after the third proves bad_cnt cleared
      run_window(50, 10, 0, 32'd1000);
      check_eq("b4_state", 32'(lock_state), S_HLD);
      check_eq("b4_errlast", 32'(err_last), 32'd10);
      run_window(50, 10, 0, 32'd1000);
      check_eq("b5_state", 32'(lock_state), S_HLD);
      run_window(50, 10, 0, 32'd1000);
      check_eq("b6_state", 32'(lock_state), S_HLD);
      run_window(50, 0, 0, 32'd1000);
      check_eq("unlock_state", 32'(lock_state), S_UNL);
      check_eq("unlock_pulses", 32'(ll_cnt), 32'd1);
      check_eq("unlock_locked", 32'(locked), 32'd0);

      // Re-acquire, then a 2000 tuning-word step drops back to UNLOCKED
      run_window(50, 0, 0, 32'd1000);
      check_eq("reacq_state", 32'(lock_state), S_ACQ);
      run_window(50, 0, 0, 32'd3000);
      check_eq("twstep_state", 32'(lock_state), S_UNL);
      for (int j = 1; j <= 16; j++) begin
         run_window(50, 0, 0, 32'd3000);
         if (j == 1)  check_eq("twstep_j1_state", 32'(lock_state), S_ACQ);
         if (j == 15) check_eq("twstep_j15_state", 32'(lock_state), S_ACQ);
      end
      check_eq("twstep_j16_state", 32'(lock_state), S_LCK);

      // Reference stops while locked
      ll_cnt = 0;
      ref_clk = 1'b0;
      for (int i = 0; i < 1100; i++) begin
         tick();
         if (lost_lock) ll_cnt++;
         if (i == 900) check_eq("to_early_reflost", 32'(ref_lost), 32'd0);
      end
      check_eq("to_reflost", 32'(ref_lost), 32'd1);
      check_eq("to_state", 32'(lock_state), S_UNL);
      check_eq("to_pulses", 32'(ll_cnt), 32'd1);
      check_eq("to_locked", 32'(locked), 32'd0);
      run_window(50, 0, 0, 32'd3000);
      check_eq("restart_reflost", 32'(ref_lost), 32'd0);
      check_eq("restart_w1_state", 32'(lock_state), S_UNL);
      run_window(50, 0, 0, 32'd3000);
      check_eq("restart_w2_state", 32'(lock_state), S_ACQ);

      // 300 error cycles in one window saturate at 255
      run_window(350, 300, 0, 32'd3000);
      run_window(50, 0, 0, 32'd3000);
      check_eq("sat_errlast", 32'(err_last), 32'd255);
      check_eq("sat_state", 32'(lock_state), S_UNL);

      // Reset mid-window
      ref_clk = 1'b1; up = 1'b1;
      repeat (20) tick();
      rst = 1'b1;
      tick();
      check_reset_outputs("midrst");
      ref_clk = 1'b0; up = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      run_window(50, 0, 0, 32'd3000);
      check_eq("post_rst_w1_state", 32'(lock_state), S_UNL);
      run_window(50, 0, 0, 32'd3000);
      check_eq("post_rst_w2_state", 32'(lock_state), S_ACQ);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lock_detector.md
LOCK_DETECTOR -- requirements
Module: lock_detector

Interface
REQ-001 Parameter PHASE_TOL, default 4: max phase-error cycles per window for a good window.
REQ-002 Parameter TW_TOL, default 32'd1024: max |tuning_word delta| between consecutive ref edges for a good window.
REQ-003 Parameter LOCK_COUNT, default 16: consecutive good windows needed to declare lock.
REQ-004 Parameter UNLOCK_COUNT, default 4: consecutive bad windows in HOLD needed to drop lock.
REQ-005 Parameter REF_TIMEOUT, default 1024: sys_clk cycles without a ref edge before reference is declared lost.
REQ-006 sys_clk  in  1  sole clock, the high-speed master clock; all state updates on its rising edge.
REQ-007 rst  in  1  synchronous reset, active-high.
REQ-008 ref_clk  in  1  reference clock, asynchronous, sampled as data.
REQ-009 up  in  1  PFD up pulse, asynchronous.
REQ-010 down  in  1  PFD down pulse, asynchronous.
REQ-011 tuning_word  in  32  loop-filter output, updated on ref_clk rise.
REQ-012 locked  out  1  high in LOCKED or HOLD.
REQ-013 lock_state  out  2  UNLOCKED=0, ACQUIRE=1, LOCKED=2, HOLD=3.
REQ-014 lost_lock  out  1  one-cycle pulse on any transition from LOCKED/HOLD to UNLOCKED.
REQ-015 ref_lost  out  1  high while the reference is timed out.
REQ-016 err_last  out  8  error count of the last closed window, saturating at 255.

Function
REQ-017 ref_clk, up and down SHALL each pass a 2-flop synchronizer; ref_edge SHALL be asserted when sync output is 1 and its previous value is 0.
REQ-018 A window SHALL span from one ref_edge cycle (inclusive) to the next ref_edge cycle (exclusive).
REQ-019 err_cnt (8 bit, saturating at 255) SHALL increment each cycle with synced up|down high; on ref_edge it SHALL load 1 if up|down is high in that cycle, else 0.
REQ-020 On ref_edge, err_last SHALL take the closing err_cnt, and tw_prev SHALL take tuning_word.
REQ-021 delta SHALL be the 32-bit unsigned absolute difference of tuning_word and tw_prev.
REQ-022 A window SHALL be good iff err_cnt <= PHASE_TOL, delta <= TW_TOL and tw_valid=1; tw_valid SHALL set at the first ref_edge after reset, so the first window is always bad.
REQ-023 The state update, err_last and lost_lock SHALL be visible on the cycle after ref_edge.
REQ-024 UNLOCKED: a good window goes to ACQUIRE with good_cnt=1.
REQ-025 ACQUIRE: a good window increments good_cnt, and good_cnt reaching LOCK_COUNT goes to LOCKED; a bad window goes to UNLOCKED with good_cnt=0.
REQ-026 LOCKED: a bad window goes to HOLD with bad_cnt=1.
REQ-027 HOLD: a good window goes to LOCKED with bad_cnt=0; a bad window increments bad_cnt, and bad_cnt reaching UNLOCK_COUNT goes to UNLOCKED and pulses lost_lock.
REQ-028 good_cnt and bad_cnt SHALL saturate and never wrap.
REQ-029 to_cnt SHALL clear on ref_edge and otherwise increment, saturating at REF_TIMEOUT.
REQ-030 When to_cnt reaches REF_TIMEOUT, the block SHALL force UNLOCKED, clear good_cnt and bad_cnt, set ref_lost, clear tw_valid, and pulse lost_lock if it was locked.
REQ-031 ref_lost SHALL clear on the next ref_edge.
REQ-032 If ref_edge and timeout coincide, ref_edge SHALL take priority.
REQ-033 tuning_word SHALL be sampled only on ref_edge, where it is stable, so no multi-bit synchronizer is used.

Reset
REQ-034 When rst is high, all outputs SHALL be 0: state UNLOCKED, locked=0, lost_lock=0, ref_lost=0, err_last=0.
REQ-035 When rst is high, all counters, tw_prev, tw_valid and synchronizer flops SHALL clear.
REQ-036 Reset mid-window SHALL discard that window, and the first ref_edge after reset SHALL only prime tw_prev.

Structure
REQ-037 Package pll_pkg SHALL hold the lock_state encodings and default tolerance constants.
REQ-038 Sub-module bit_sync SHALL provide the 2-flop synchronizer with optional rising-edge output, instantiated three times.

Verification
REQ-039 Scenario: ref period 50 cycles, up/down low, tuning_word constant -> ACQUIRE after window 2, LOCKED after window 17, locked=1.
REQ-040 Scenario: from LOCKED, up high 10 cycles per window for 4 windows -> HOLD after the first, UNLOCKED plus a one-cycle lost_lock after the fourth.
REQ-041 Scenario: from HOLD with bad_cnt=2, one clean window -> LOCKED, bad_cnt=0, no lost_lock.
REQ-042 Scenario: tuning_word steps by 2000 in ACQUIRE -> UNLOCKED, good_cnt=0.
REQ-043 Scenario: ref_clk stopped 1024 cycles while LOCKED -> ref_lost=1, lost_lock pulse, UNLOCKED; the ref restarting clears ref_lost and the first window is bad.
REQ-044 Scenario: up held high 300 cycles -> err_last=255 with no wrap; rst pulse mid-window -> all outputs 0 the next cycle.
